// File: rtl/bicubic_tile_serializer_if.sv
// bicubic_tile_serializer_if
//
// Bundles the two handshakes of the tile serializer.
//   Tile side  : bcci_rsp_valid / bf_rsp_ready, pixels bcci_rsp_data1..16
//                (row-major, data1-4 = row 0 ... data13-16 = row 3).
//   Pixel side : sr_out_valid / sr_out_ready, sr_out_data, sr_out_row,
//                sr_out_col, sr_out_last.
// The slave modport is the serializer itself; the master modport is the
// surrounding environment (tile producer plus pixel consumer).

interface bicubic_tile_serializer_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                     bcci_rsp_valid;
    logic                     bf_rsp_ready;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data5;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data6;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data7;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data8;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data9;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data10;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data11;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data12;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data13;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data14;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data15;
    logic [CHANNEL_WIDTH-1:0] bcci_rsp_data16;

    logic                     sr_out_valid;
    logic                     sr_out_ready;
    logic [CHANNEL_WIDTH-1:0] sr_out_data;
    logic [1:0]               sr_out_row;
    logic [1:0]               sr_out_col;
    logic                     sr_out_last;

    modport slave (
        input  bcci_rsp_valid,
        input  bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
        input  bcci_rsp_data5, bcci_rsp_data6, bcci_rsp_data7, bcci_rsp_data8,
        input  bcci_rsp_data9, bcci_rsp_data10, bcci_rsp_data11, bcci_rsp_data12,
        input  bcci_rsp_data13, bcci_rsp_data14, bcci_rsp_data15, bcci_rsp_data16,
        output bf_rsp_ready,
        output sr_out_valid, sr_out_data, sr_out_row, sr_out_col, sr_out_last,
        input  sr_out_ready
    );

    modport master (
        output bcci_rsp_valid,
        output bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
        output bcci_rsp_data5, bcci_rsp_data6, bcci_rsp_data7, bcci_rsp_data8,
        output bcci_rsp_data9, bcci_rsp_data10, bcci_rsp_data11, bcci_rsp_data12,
        output bcci_rsp_data13, bcci_rsp_data14, bcci_rsp_data15, bcci_rsp_data16,
        input  bf_rsp_ready,
        input  sr_out_valid, sr_out_data, sr_out_row, sr_out_col, sr_out_last,
        output sr_out_ready
    );
endinterface

// File: rtl/bicubic_tile_serializer.sv
// bicubic_tile_serializer
//
// Accepts 4x4 upsampled tiles and replays each one as 16 single-pixel beats
// in row-major order. Two tiles can be held at once (ping-pong buffer) so a
// new tile can be loaded while the previous one is still being emitted.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : bicubic_tile_serializer_if.slave
//          tile in  : bcci_rsp_valid, bcci_rsp_data1..16, bf_rsp_ready
//          pixel out: sr_out_valid, sr_out_ready, sr_out_data, sr_out_row,
//                     sr_out_col, sr_out_last

module bicubic_tile_serializer #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    bicubic_tile_serializer_if.slave        bus
);

    logic [CHANNEL_WIDTH-1:0] tile_mem [2][16];
    logic [CHANNEL_WIDTH-1:0] tile_in  [16];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [3:0] beat;

    logic in_ready;
    logic out_valid;
    logic tile_hs;
    logic pixel_hs;
    logic last_hs;

    // Flatten the sixteen tile ports into an indexable array, row-major.
    assign tile_in[0]  = bus.bcci_rsp_data1;
    assign tile_in[1]  = bus.bcci_rsp_data2;
    assign tile_in[2]  = bus.bcci_rsp_data3;
    assign tile_in[3]  = bus.bcci_rsp_data4;
    assign tile_in[4]  = bus.bcci_rsp_data5;
    assign tile_in[5]  = bus.bcci_rsp_data6;
    assign tile_in[6]  = bus.bcci_rsp_data7;
    assign tile_in[7]  = bus.bcci_rsp_data8;
    assign tile_in[8]  = bus.bcci_rsp_data9;
    assign tile_in[9]  = bus.bcci_rsp_data10;
    assign tile_in[10] = bus.bcci_rsp_data11;
    assign tile_in[11] = bus.bcci_rsp_data12;
    assign tile_in[12] = bus.bcci_rsp_data13;
    assign tile_in[13] = bus.bcci_rsp_data14;
    assign tile_in[14] = bus.bcci_rsp_data15;
    assign tile_in[15] = bus.bcci_rsp_data16;

    // Ready looks only at the registered occupancy, so a full buffer keeps
    // ready low even in the cycle its last beat drains; it comes back the
    // cycle after. Reset forces both handshake qualifiers low.
    assign in_ready  = (count != 2'd2) & ~rst;
    assign out_valid = (count != 2'd0) & ~rst;

    assign tile_hs  = bus.bcci_rsp_valid & in_ready;
    assign pixel_hs = out_valid & bus.sr_out_ready;
    assign last_hs  = pixel_hs & (beat == 4'd15);

    assign bus.bf_rsp_ready = in_ready;
    assign bus.sr_out_valid = out_valid;
    assign bus.sr_out_data  = out_valid ? tile_mem[rd_ptr][beat] : '0;
    assign bus.sr_out_row   = rst ? 2'd0 : beat[3:2];
    assign bus.sr_out_col   = rst ? 2'd0 : beat[1:0];
    assign bus.sr_out_last  = ~rst & (beat == 4'd15);

    // Pixel storage carries no reset; occupancy alone decides what is valid.
    // A write can never land on the entry being read because ready is low
    // whenever both entries are occupied.
    always_ff @(posedge clk) begin
        if (tile_hs) begin
            for (int k = 0; k < 16; k++) begin
                tile_mem[wr_ptr][k] <= tile_in[k];
            end
        end
    end

    // Pointer, occupancy and beat bookkeeping. A tile arriving in the same
    // cycle the current tile finishes leaves the occupancy unchanged while
    // both pointers advance, so the next tile starts without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            beat   <= 4'd0;
        end else begin
            if (tile_hs) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pixel_hs) begin
                beat <= beat + 4'd1;
            end
            if (last_hs) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({tile_hs, last_hs})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_tile_serializer.sv
// tb_bicubic_tile_serializer
//
// Randomised scoreboard bench for bicubic_tile_serializer. Each accepted
// tile expands into sixteen expected beats in a queue; a negedge monitor
// pops on every pixel handshake and also checks valid/ready against the
// number of tiles the queue says are still held.

module tb_bicubic_tile_serializer;

    localparam int CW = 8;

    typedef struct {
        logic [CW-1:0] data;
        logic [1:0]    row;
        logic [1:0]    col;
        logic          last;
    } beat_t;

    logic clk;
    logic rst;

    bicubic_tile_serializer_if #(.CHANNEL_WIDTH(CW)) bus ();

    bicubic_tile_serializer #(.CHANNEL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] tile_px [16];
    beat_t         exp_q [$];
    beat_t         exp_beat;
    int            ready_mode;

    logic          prev_stall;
    logic [CW-1:0] prev_data;
    logic [1:0]    prev_row;
    logic [1:0]    prev_col;
    logic          prev_last;

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Put the current tile_px onto the tile bus.
    task automatic driveData();
        bus.bcci_rsp_data1  = tile_px[0];
        bus.bcci_rsp_data2  = tile_px[1];
        bus.bcci_rsp_data3  = tile_px[2];
        bus.bcci_rsp_data4  = tile_px[3];
        bus.bcci_rsp_data5  = tile_px[4];
        bus.bcci_rsp_data6  = tile_px[5];
        bus.bcci_rsp_data7  = tile_px[6];
        bus.bcci_rsp_data8  = tile_px[7];
        bus.bcci_rsp_data9  = tile_px[8];
        bus.bcci_rsp_data10 = tile_px[9];
        bus.bcci_rsp_data11 = tile_px[10];
        bus.bcci_rsp_data12 = tile_px[11];
        bus.bcci_rsp_data13 = tile_px[12];
        bus.bcci_rsp_data14 = tile_px[13];
        bus.bcci_rsp_data15 = tile_px[14];
        bus.bcci_rsp_data16 = tile_px[15];
    endtask

    // Offer tile_px and hold it until the serializer takes it.
    task automatic applyStimulus();
        int waited;
        waited = 0;
        driveData();
        bus.bcci_rsp_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.bf_rsp_ready) break;
            waited++;
            if (waited > 500) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.bcci_rsp_valid = 1'b0;
    endtask

    task automatic fillTile(input int base);
        for (int k = 0; k < 16; k++) tile_px[k] = CW'(base + k + 1);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            waited++;
            if (waited > 5000) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout actual=%0d required=0 at %0t", exp_q.size(), $time);
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Downstream ready pattern: 0 = always, 1 = random 50%, 2 = stalled.
    initial begin
        bus.sr_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.sr_out_ready = 1'b1;
                1:       bus.sr_out_ready = 1'($urandom_range(0, 1));
                default: bus.sr_out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_valid", 32'(bus.sr_out_valid), 0);
            checkOutput("rst_ready", 32'(bus.bf_rsp_ready), 0);
            checkOutput("rst_data",  32'(bus.sr_out_data), 0);
            checkOutput("rst_row",   32'(bus.sr_out_row), 0);
            checkOutput("rst_col",   32'(bus.sr_out_col), 0);
            checkOutput("rst_last",  32'(bus.sr_out_last), 0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            checkOutput("out_valid", 32'(bus.sr_out_valid), 32'(exp_q.size() != 0));
            checkOutput("in_ready",  32'(bus.bf_rsp_ready), 32'(exp_q.size() <= 16));
            if (prev_stall) begin
                checkOutput("stall_data", 32'(bus.sr_out_data), 32'(prev_data));
                checkOutput("stall_row",  32'(bus.sr_out_row),  32'(prev_row));
                checkOutput("stall_col",  32'(bus.sr_out_col),  32'(prev_col));
                checkOutput("stall_last", 32'(bus.sr_out_last), 32'(prev_last));
            end
            if (bus.sr_out_valid && bus.sr_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_beat actual=0x%0h required=none at %0t", bus.sr_out_data, $time);
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("beat_data", 32'(bus.sr_out_data), 32'(exp_beat.data));
                    checkOutput("beat_row",  32'(bus.sr_out_row),  32'(exp_beat.row));
                    checkOutput("beat_col",  32'(bus.sr_out_col),  32'(exp_beat.col));
                    checkOutput("beat_last", 32'(bus.sr_out_last), 32'(exp_beat.last));
                end
            end
            if (bus.bcci_rsp_valid && bus.bf_rsp_ready) begin
                for (int k = 0; k < 16; k++) begin
                    exp_beat.data = tile_px[k];
                    exp_beat.row  = 2'(k / 4);
                    exp_beat.col  = 2'(k % 4);
                    exp_beat.last = (k == 15);
                    exp_q.push_back(exp_beat);
                end
            end
            prev_stall = bus.sr_out_valid && !bus.sr_out_ready;
            prev_data  = bus.sr_out_data;
            prev_row   = bus.sr_out_row;
            prev_col   = bus.sr_out_col;
            prev_last  = bus.sr_out_last;
        end
    end

    // Test sequence.
    initial begin
        int waited;
        rst                = 1'b1;
        ready_mode         = 0;
        bus.bcci_rsp_valid = 1'b0;
        fillTile(0);
        driveData();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single tile, data 1..16");
        fillTile(0);
        applyStimulus();
        waitDrain();

        $display("[TB] three tiles against a stalled consumer");
        ready_mode = 2;
        fork
            begin
                fillTile(16'h10);
                applyStimulus();
                fillTile(16'h20);
                applyStimulus();
                fillTile(16'h30);
                applyStimulus();
            end
            begin
                repeat (25) @(posedge clk);
                ready_mode = 0;
            end
        join
        waitDrain();

        $display("[TB] 100 random tiles, random consumer");
        ready_mode = 1;
        for (int t = 0; t < 100; t++) begin
            for (int k = 0; k < 16; k++) tile_px[k] = CW'($urandom_range(0, 255));
            applyStimulus();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain();

        $display("[TB] reset mid-tile with a second tile buffered");
        ready_mode = 0;
        fillTile(16'h40);
        applyStimulus();
        fillTile(16'h50);
        applyStimulus();
        waited = 0;
        while (!(bus.sr_out_valid && bus.sr_out_row == 2'd1 && bus.sr_out_col == 2'd3)) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat7_timeout actual=absent required=present at %0t", $time);
                break;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fillTile(16'hA0);
        applyStimulus();
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
